// File: rtl/i2c_slave.sv
// Byte-level I2C target: START/STOP detection, 7-bit address match, write receive with ACK,
// read transmit from a host-side byte interface. Open-drain SDA only, SCL is never driven.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  inout  wire        sda_io,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  output logic       rd_req_o,
  output logic       busy_o,
  output logic [3:0] debug_state_o,
  output logic       debug_sda_oe_o
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StAddr    = 4'd1,
    StAddrAck = 4'd2,
    StWrData  = 4'd3,
    StWrAck   = 4'd4,
    StRdData  = 4'd5,
    StRdAck   = 4'd6,
    StIgnore  = 4'd7
  } state_e;

  state_e     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       rw_q;
  logic       mack_q;
  logic       sda_oe_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       rd_req_q;
  logic       busy_q;

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  logic scl_rise, scl_fall, start_ev, stop_ev;

  // Open-drain: only ever pull low.
  assign sda_io = sda_oe_q ? 1'b0 : 1'bz;

  // Two-stage synchronisers plus a previous-value copy for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_io;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise = scl_sync_q & ~scl_prev_q;
  assign scl_fall = ~scl_sync_q & scl_prev_q;
  assign start_ev = sda_prev_q & ~sda_sync_q & scl_sync_q;
  assign stop_ev  = ~sda_prev_q & sda_sync_q & scl_sync_q;

  // Protocol FSM; STOP beats START beats SCL edges. SDA only changes after an scl_fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      if (stop_ev) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_ev) begin
        state_q   <= StAddr;
        bit_cnt_q <= 3'd0;
        sda_oe_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: sda_oe_q <= 1'b0;
          StAddr: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_sync_q};
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q <= 3'd0;
                // shift_q[6:0] holds the address bits, the live sample is R/W.
                if (shift_q[6:0] == SLAVE_ADDR) begin
                  busy_q  <= 1'b1;
                  rw_q    <= sda_sync_q;
                  state_q <= StAddrAck;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= StIgnore;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
                rd_req_q <= rw_q;
              end else if (rw_q) begin
                shift_q   <= tx_data_i;
                sda_oe_q  <= ~tx_data_i[7];
                bit_cnt_q <= 3'd0;
                state_q   <= StRdData;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= StWrData;
              end
            end
          end
          StWrData: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_sync_q};
              if (bit_cnt_q == 3'd7) begin
                rx_data_q  <= {shift_q[6:0], sda_sync_q};
                rx_valid_q <= 1'b1;
                bit_cnt_q  <= 3'd0;
                state_q    <= StWrAck;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          StWrAck: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= StWrData;
              end
            end
          end
          StRdData: begin
            if (scl_fall) begin
              if (bit_cnt_q == 3'd7) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
                mack_q    <= 1'b0;
                state_q   <= StRdAck;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shift_q   <= {shift_q[6:0], 1'b0};
                sda_oe_q  <= ~shift_q[6];
              end
            end
          end
          StRdAck: begin
            if (scl_rise && !mack_q) begin
              if (!sda_sync_q) begin
                mack_q   <= 1'b1;
                rd_req_q <= 1'b1;
              end else begin
                busy_q  <= 1'b0;
                state_q <= StIgnore;
              end
            end else if (scl_fall && mack_q) begin
              shift_q   <= tx_data_i;
              sda_oe_q  <= ~tx_data_i[7];
              bit_cnt_q <= 3'd0;
              state_q   <= StRdData;
            end
          end
          StIgnore: sda_oe_q <= 1'b0;
          default: begin
            state_q  <= StIdle;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rd_req_o       = rd_req_q;
  assign busy_o         = busy_q;
  assign debug_state_o  = state_q;
  assign debug_sda_oe_o = sda_oe_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master, a tx_data provider and a scoreboard monitor.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 25;                  // quarter SCL period in clk cycles
  localparam logic [6:0] MyAddr = 7'h55;
  localparam logic [3:0] StIdleEnc = 4'd0;
  localparam logic [3:0] StIgnoreEnc = 4'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda_w;
  logic [7:0] rx_data;
  logic       rx_valid, rd_req, busy, dbg_oe;
  logic [3:0] dbg_state;

  pullup (sda_w);
  assign sda_w = m_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(MyAddr)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_io(sda_w),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .tx_data_i(tx_data), .rd_req_o(rd_req),
    .busy_o(busy), .debug_state_o(dbg_state), .debug_sda_oe_o(dbg_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_rx[$];
  int         exp_rd[$];
  logic [7:0] tx_tbl[64];
  int         prov_idx = 0;
  int         model_ptr = 0;
  int         req_ctr = 0;
  bit         addressed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, tx_data provider and SDA-stability watch.
  logic prev_oe = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
      else chk("rx_data", rx_data, exp_rx.pop_front());
    end
    if (rd_req) begin
      if (exp_rd.size() == 0) chk("rd_req_unexpected", 1, 0);
      else chk("rd_req_order", prov_idx, exp_rd.pop_front());
      tx_data = tx_tbl[prov_idx % 64];
      prov_idx++;
    end
    if (dbg_oe != prev_oe) chk("sda_change_scl_low", scl, 0);
    prev_oe = dbg_oe;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    m_low = 1'b0; wq(Q);
    scl = 1'b1;   wq(2 * Q);
    m_low = 1'b1; wq(2 * Q);
    scl = 1'b0;   wq(Q);
  endtask

  task automatic stop_cond();
    m_low = 1'b1; wq(Q);
    scl = 1'b1;   wq(2 * Q);
    m_low = 1'b0; wq(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; wq(Q);
    scl = 1'b1; wq(2 * Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; wq(Q);
    scl = 1'b1;   wq(Q);
    b = sda_w;    wq(Q);
    scl = 1'b0;   wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  // START (or repeated START) plus address byte; model decides whether the target answers.
  task automatic txn_begin(input logic [6:0] addr, input logic rw);
    logic ack;
    addressed = (addr == MyAddr);
    if (addressed && rw) exp_rd.push_back(req_ctr++);
    start_cond();
    write_byte({addr, rw}, ack);
    chk("addr_ack", ack, addressed ? 0 : 1);
    chk("busy_after_addr", busy, addressed);
  endtask

  task automatic write_data(input logic [7:0] b);
    logic ack;
    exp_rx.push_back(b);
    write_byte(b, ack);
    chk("data_ack", ack, 0);
  endtask

  task automatic read_data(input int n);
    logic [7:0] b;
    logic bit_v;
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        recv_bit(bit_v);
        b[i] = bit_v;
      end
      chk("rd_byte", b, tx_tbl[model_ptr % 64]);
      model_ptr++;
      if (k < n - 1) begin
        exp_rd.push_back(req_ctr++);
        send_bit(1'b0);
      end else begin
        send_bit(1'b1);
      end
    end
  endtask

  task automatic finish_txn();
    stop_cond();
    wq(8);
    chk("busy_after_stop", busy, 0);
    chk("idle_after_stop", dbg_state, StIdleEnc);
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
  endtask

  initial begin
    logic ack;
    logic [6:0] a;
    for (int i = 0; i < 64; i++) tx_tbl[i] = 8'($urandom);
    tx_tbl[0] = 8'h3C;
    tx_tbl[1] = 8'hC3;
    tx_tbl[2] = 8'hC3;
    wq(10);
    chk("rst_state", dbg_state, StIdleEnc);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_sda_oe", dbg_oe, 0);
    rst = 1'b0;
    wq(10);

    // Single-byte write.
    txn_begin(MyAddr, 1'b0);
    write_data(8'hA5);
    finish_txn();
    chk("t1_rx_data", rx_data, 8'hA5);

    // Foreign address is ignored until STOP.
    txn_begin(7'h22, 1'b0);
    chk("t2_ignore", dbg_state, StIgnoreEnc);
    finish_txn();

    // Single-byte read, master NACKs.
    txn_begin(MyAddr, 1'b1);
    read_data(1);
    wq(8);
    chk("t3_sda_released", sda_w, 1);
    chk("t3_ignore", dbg_state, StIgnoreEnc);
    finish_txn();

    // Two-byte write.
    txn_begin(MyAddr, 1'b0);
    write_data(8'hA5);
    write_data(8'h3C);
    finish_txn();

    // Write, repeated START, two-byte read.
    txn_begin(MyAddr, 1'b0);
    write_data(8'h10);
    txn_begin(MyAddr, 1'b1);
    read_data(2);
    finish_txn();
    chk("t5_rx_data", rx_data, 8'h10);

    // Reset while the target holds the ACK low.
    txn_begin(MyAddr, 1'b0);
    exp_rx.push_back(8'h77);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h77 >> i));
    m_low = 1'b0; wq(Q);
    chk("t6_ack_driven", sda_w, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_sda_released", sda_w, 1);
    chk("t6_state", dbg_state, StIdleEnc);
    chk("t6_rx_data", rx_data, 8'h00);
    chk("t6_busy", busy, 0);
    chk("t6_rd_req", rd_req, 0);
    chk("t6_rx_valid", rx_valid, 0);
    wq(3);
    rst = 1'b0;
    scl = 1'b1; wq(Q);
    finish_txn();
    txn_begin(MyAddr, 1'b0);
    write_data(8'h5A);
    finish_txn();

    // Randomized transactions against the model.
    for (int t = 0; t < 8; t++) begin
      int n;
      logic rw;
      n  = $urandom_range(1, 3);
      rw = 1'($urandom);
      if ($urandom_range(0, 3) != 0) a = MyAddr;
      else begin
        a = 7'($urandom);
        if (a == MyAddr) a = 7'h2A;
      end
      txn_begin(a, rw);
      if (!addressed) chk("rnd_ignore", dbg_state, StIgnoreEnc);
      else if (rw) read_data(n);
      else for (int k = 0; k < n; k++) write_data(8'($urandom));
      finish_txn();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
